// File: rtl/spi_dac_out.sv
// Serialises one 10-bit sample per accepted strobe into a 16-bit SYNC-framed
// frame for a DAC121S101-style 12-bit DAC; flags strobes dropped mid-frame.
module spi_dac_out #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SAMPLE_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_rate,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                dac_sclk,
  output logic                dac_sync_n,
  output logic                dac_din,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CW = HW + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [14:0]   sreg;
  logic [15:0]   frame;

  // Sample left-aligned in the 12-bit code, power-down bits zero.
  assign frame = {4'b0000, sample_in, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_din    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_rate) begin
            state      <= SHIFT;
            sreg       <= frame[14:0];
            dac_din    <= frame[15];
            dac_sync_n <= 1'b0;
            dac_sclk   <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          if (sample_rate) overrun <= 1'b1;
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (dac_sclk) begin
              // Falling edge: the DAC samples dac_din here.
              dac_sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 5'd1;
            end else if (bit_cnt == 5'd16) begin
              dac_sclk   <= 1'b1;
              dac_sync_n <= 1'b1;
              dac_din    <= 1'b0;
              state      <= HOLD;
            end else begin
              dac_sclk <= 1'b1;
              dac_din  <= sreg[14];
              sreg     <= {sreg[13:0], 1'b0};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (sample_rate) overrun <= 1'b1;
          // SYNC-high guard time of two SCLK half-periods.
          if (cnt == HOLD_LAST) begin
            cnt        <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dac_out.sv
// Directed bench for spi_dac_out: a scoreboard of expected frames is checked
// against the bits captured on each dac_sclk falling edge.
module tb_spi_dac_out;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_rate = 1'b0;
  logic [9:0] sample_in = '0;
  logic       dac_sclk, dac_sync_n, dac_din, busy, frame_done, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] sb[$];
  logic [15:0] cap = '0;
  logic [15:0] e;
  int          nb = 0;
  logic        p_din = 1'b0, p_sclk = 1'b1, p_sync = 1'b1;

  spi_dac_out #(.CLK_DIV(D), .SAMPLE_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_rate(sample_rate),
    .sample_in  (sample_in),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_din    (dac_din),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fr(input logic [9:0] s);
    return {4'b0000, s, 2'b00};
  endfunction

  function automatic logic [5:0] outs();
    return {dac_sclk, dac_sync_n, dac_din, busy, frame_done, overrun};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called in cycle T, returns in cycle T+1.
  task automatic strobe(input logic [9:0] s);
    sample_rate = 1'b1;
    sample_in   = s;
    @(negedge clk);
    sample_rate = 1'b0;
    sample_in   = 10'($urandom);
  endtask

  // Frame capture as the DAC would see it.
  always @(negedge dac_sync_n) begin
    cap = '0;
    nb  = 0;
  end

  always @(negedge dac_sclk) begin
    if (!rst && !dac_sync_n) begin
      cap = {cap[14:0], dac_din};
      nb++;
    end
  end

  always @(posedge dac_sync_n) begin
    if (rst) begin
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      chk("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame_bits", 32'(nb), 32'd16);
        chk("frame_data", 32'(cap), 32'(e));
      end
    end
  end

  // dac_din may only move with a rising SCLK or a SYNC transition.
  always @(negedge clk) begin
    if (!rst && dac_din !== p_din)
      chk("din_change_on_sclk_rise",
          32'((dac_sclk && !p_sclk) || (dac_sync_n !== p_sync)), 32'd1);
    p_din  = dac_din;
    p_sclk = dac_sclk;
    p_sync = dac_sync_n;
  end

  initial begin
    step(2);
    chk("reset_outs", 32'(outs()), 32'(6'b110000));
    rst = 1'b0;
    step(5);

    // Single frame, full cycle-accurate timeline.
    sb.push_back(fr(10'h2AB));
    strobe(10'h2AB);
    chk("start_outs", 32'(outs()), 32'(6'b100100));
    step(D);
    chk("first_fall", 32'(dac_sclk), 32'd0);
    step(128 - 1 - D);
    chk("sync_last_low", 32'(dac_sync_n), 32'd0);
    step(1);
    chk("hold_entry", 32'(outs()), 32'(6'b110100));
    step(7);
    chk("last_hold", 32'({busy, frame_done}), 32'(2'b10));
    step(1);
    chk("frame_done", 32'(outs()), 32'(6'b110010));
    step(1);
    chk("done_pulse_width", 32'(frame_done), 32'd0);
    step(20);

    // Full scale and zero.
    sb.push_back(fr(10'h3FF));
    strobe(10'h3FF);
    step(150);
    sb.push_back(fr(10'h000));
    strobe(10'h000);
    step(150);
    chk("no_overrun", 32'(overrun), 32'd0);

    // Overrun mid-SHIFT.
    sb.push_back(fr(10'h123));
    strobe(10'h123);
    step(49);
    strobe(10'h155);
    chk("overrun_set", 32'(overrun), 32'd1);
    step(300);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("sb_empty_after_overrun", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a frame, then a strobe during reset.
    sb.push_back(fr(10'h0AA));
    strobe(10'h0AA);
    step(30);
    #2 rst = 1'b1;
    #1 chk("async_reset_outs", 32'(outs()), 32'(6'b110000));
    @(negedge clk);
    sample_rate = 1'b1;
    @(negedge clk);
    sample_rate = 1'b0;
    step(1);
    chk("strobe_in_reset_ignored", 32'(outs()), 32'(6'b110000));
    rst = 1'b0;
    step(3);
    chk("sb_after_reset", 32'(sb.size()), 32'd0);
    chk("idle_after_reset", 32'(outs()), 32'(6'b110000));

    // Strobe in the last HOLD cycle is dropped.
    sb.push_back(fr(10'h301));
    strobe(10'h301);
    step(135);
    strobe(10'h0F0);
    chk("overrun_last_hold", 32'({overrun, frame_done}), 32'(2'b11));
    step(20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Strobe in the frame_done cycle is accepted.
    sb.push_back(fr(10'h1C7));
    strobe(10'h1C7);
    step(136);
    chk("done_cycle", 32'(frame_done), 32'd1);
    sb.push_back(fr(10'h238));
    strobe(10'h238);
    chk("accept_on_done", 32'({dac_sync_n, busy, overrun}), 32'(3'b010));
    step(150);

    // Streaming ramp.
    for (int n = 0; n < 64; n++) begin
      sb.push_back(fr(10'(n)));
      strobe(10'(n));
      step(139);
    end
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("stream_no_overrun", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_dac_out.md
# spi_dac_out

Output stage that takes the mixed 10-bit voice sum and drives an external 12-bit serial DAC (DAC121S101-compatible, 16-bit frame, SYNC-framed SPI). It sits directly downstream of the synth top-level sample register and is clocked by the same system clock. It uses the same sample-rate strobe that paces the voices. It serialises one sample per accepted strobe and flags any strobe that arrives while a frame is still in flight.

## Interface
- CLK_DIV, 4, system clocks per SCLK half-period; legal range is 2..255.
- SAMPLE_W, 10, width of `sample_in`; fixed at 10.
- clk  in  1  system clock; everything in the block is on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- sample_rate  in  1  one-cycle strobe per output sample (prescaler ceo, 1 per 3125 clk).
- sample_in  in  10  unsigned sample; sampled only on an accepted strobe.
- dac_sclk  out  1  serial clock; idles high; the DAC captures on the falling edge.
- dac_sync_n  out  1  frame select, active low.
- dac_din  out  1  serial data, MSB first; changes only on SCLK rising edges.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when the block returns to IDLE.
- overrun  out  1  sticky flag: a strobe was dropped; cleared only by rst.

## Operation
- States: IDLE, SHIFT, HOLD. All outputs are registered.
- **Frame format:** frame[15:0] = {2'b00 don't-care, PD1 PD0 = 2'b00, sample_in[9:0], 2'b00}.
  - The 10-bit sample is left-aligned into the 12-bit DAC code.
  - No arithmetic, no saturation.
- **IDLE:** a strobe is accepted when `sample_rate`=1 in IDLE.
  - Latch frame into the shift register.
  - Go to SHIFT.
  - Clear the half-period counter and the bit counter.
- **SHIFT:** the half-period counter counts 0..CLK_DIV-1; on wrap, dac_sclk toggles.
  - On a falling toggle: nothing else changes (the DAC samples here).
  - On a rising toggle: the shift register moves left and dac_din takes the next bit.
  - After 16 falling edges, the next rising toggle ends the frame:
    - dac_sync_n goes to 1 and dac_din goes to 0.
    - Enter HOLD.
- **HOLD:** dac_sync_n stays high and dac_sclk stays high for 2*CLK_DIV cycles, then enter IDLE.
  - This satisfies the DAC minimum SYNC-high time.
- **busy** = (state != IDLE), registered alongside the state.
- **frame_done** is high exactly in the first IDLE cycle after HOLD.
  - A strobe in that same cycle is accepted normally.
- **Overrun:** a strobe while state is SHIFT or HOLD (including the last HOLD cycle) is dropped.
  - overrun is set to 1.
  - The frame in flight and its latched data are unaffected.
  - sample_in is not re-sampled.
- **Counter widths:** the half-period counter is clog2(CLK_DIV) bits; the bit counter is 5 bits; HOLD reuses the half-period counter plus 1 extra bit.

## Timing
- **Reset values (async, immediate):**
  - dac_sclk=1, dac_sync_n=1, dac_din=0.
  - busy=0, frame_done=0, overrun=0.
  - State is IDLE and the shift register is 0.
- Let D = CLK_DIV, and let the strobe be accepted at edge T (present in cycle T).
- **Cycle T+1:** dac_sync_n=0, dac_sclk=1, dac_din=frame[15], busy=1.
- **Bit index i (0..15, bit 15-i):**
  - Valid on dac_din from cycle T+1+2iD.
  - dac_sclk falls at T+1+(2i+1)D.
  - dac_sclk rises at T+1+(2i+2)D.
- **Cycle T+1+32D:** dac_sclk=1, dac_sync_n=1, dac_din=0, HOLD entered.
- **Cycle T+1+34D:** IDLE, busy=0, frame_done=1.
  - Total busy time is 34D cycles; D=4 gives 136 cycles, well inside the 3125-cycle sample period.
- **Reset asserted mid-frame:** all outputs go to reset values immediately, and the partial frame is abandoned.
  - The DAC discards it because SYNC rises before the 16th falling edge.
  - After reset release, the first strobe starts a fresh frame.
- Strobe during reset: ignored.
- sample_in changes outside the accepted-strobe cycle: no effect.

## Test plan
- **Reset:** assert rst mid-SHIFT with D=4.
  - Outputs go to sclk=1, sync_n=1, din=0, busy=0, frame_done=0, overrun=0 in the same cycle, with no clock edge needed.
- **Single frame:** sample_in=10'h2AB, D=4, strobe at T.
  - The bits captured on the 16 sclk falling edges equal 16'h0AAC.
  - sync_n is low from T+1 to T+128.
  - frame_done pulses at T+137.
- **Full scale and zero:**
  - sample_in=10'h3FF gives captured frame 16'h0FFC.
  - sample_in=10'h000 gives captured frame 16'h0000.
  - din is stable across every falling edge.
- **Overrun:** second strobe at T+50 with a different sample.
  - overrun=1 from T+51 and stays set.
  - The captured frame is still the first sample, and no second frame follows.
- **Boundary strobes (D=4):**
  - Strobe at T+136 (last HOLD cycle): dropped, overrun=1.
  - Strobe at T+137 (frame_done cycle): accepted, sync_n low at T+138, overrun stays 0.
- **Streaming:** 64 strobes at the 3125-cycle period with sample_in ramping 0..63.
  - 64 frames are produced, each captured frame equals {4'b0, n, 2'b00}, and overrun stays 0.
